pc_io_controller: RTL and testbench

PC_IO_CONTROLLER -- requirements
Module: pc_io_controller

---
 rtl/pc_io_controller.sv | 144 ++++++++++++++
 tb/tb_pc_io_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_io_controller.sv
// pc_io_controller
//   Stalls the processor on I/O instructions until the user presses Enter.
//   Each accepted press advances exactly one I/O instruction.
//   The FSM debounces Enter and then waits for it to be released, so holding
//   the button does not run through several I/O instructions.
//
// Ports
//   clk, reset        rising-edge clock; synchronous active-low reset
//   Enter             raw user button (active-high)
//   Input/Output/Halt decoded class of the current instruction
//   sw_data           switch value, sampled into in_data while waiting
//   reg_data          register value, latched into disp_data on Output accept
//   pc_en / stall     PC load enable and its complement
//   in_data/in_valid  switch sample and its register-file write enable
//   disp_data/_valid  display register and one-cycle update strobe
//   waiting / halted  status: awaiting a press / processor stopped
module pc_io_controller #(
  parameter int DATA_WIDTH      = 32,
  parameter int DEBOUNCE_CYCLES = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Enter,
  input  logic                  Input,
  input  logic                  Output,
  input  logic                  Halt,
  input  logic [DATA_WIDTH-1:0] sw_data,
  input  logic [DATA_WIDTH-1:0] reg_data,
  output logic                  pc_en,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_valid,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic                  disp_valid,
  output logic                  waiting,
  output logic                  halted
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // count value on the last high sample needed for acceptance
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    RUN,
    WAIT_PRESS,
    DEBOUNCE,
    WAIT_RELEASE,
    HALTED
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    op_in_q, op_in_d;
  logic [DATA_WIDTH-1:0]   in_data_q;
  logic [DATA_WIDTH-1:0]   disp_data_q;
  logic                    disp_valid_q;
  logic                    pc_en_raw;
  logic                    accept;
  logic                    in_wait;

  // Next-state and PC enable
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_in_d   = op_in_q;
    pc_en_raw = 1'b0;
    accept    = 1'b0;
    case (state_q)
      RUN: begin
        if (Halt) begin
          state_d = HALTED;
        end else if (Input || Output) begin
          // Input wins when both are decoded together
          state_d = WAIT_PRESS;
          op_in_d = Input;
        end else begin
          pc_en_raw = 1'b1;
        end
      end
      WAIT_PRESS: begin
        if (Enter) begin
          state_d = DEBOUNCE;
          count_d = CW'(1);
        end
      end
      DEBOUNCE: begin
        if (!Enter) begin
          // any low sample restarts the debounce window
          state_d = WAIT_PRESS;
          count_d = '0;
        end else if (count_q == CNT_LAST) begin
          accept    = 1'b1;
          pc_en_raw = 1'b1;
          state_d   = WAIT_RELEASE;
          count_d   = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      WAIT_RELEASE: begin
        if (!Enter) state_d = RUN;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
        count_d = '0;
      end
    endcase
  end

  assign in_wait = (state_q == WAIT_PRESS) || (state_q == DEBOUNCE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      count_q      <= '0;
      op_in_q      <= 1'b0;
      in_data_q    <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      op_in_q      <= op_in_d;
      // keep tracking the switches while the user may still change them
      if (in_wait) in_data_q <= sw_data;
      disp_valid_q <= accept && !op_in_q;
      if (accept && !op_in_q) disp_data_q <= reg_data;
    end
  end

  // reset gates the combinational strobes so an aborted operation never fires
  assign pc_en      = reset && pc_en_raw;
  assign stall      = !pc_en;
  assign in_valid   = reset && accept && op_in_q;
  assign in_data    = in_data_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign waiting    = in_wait;
  assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_pc_io_controller.sv
module tb_pc_io_controller;
  localparam int DW = 32;
  localparam int DC = 6;

  logic clk = 1'b0;
  logic reset = 1'b0, Enter = 1'b0, Input = 1'b0, Output = 1'b0, Halt = 1'b0;
  logic [DW-1:0] sw_data = '0, reg_data = '0;
  logic pc_en, stall, in_valid, disp_valid, waiting, halted;
  logic [DW-1:0] in_data, disp_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_io_controller #(.DATA_WIDTH(DW), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Enter(Enter), .Input(Input), .Output(Output),
    .Halt(Halt), .sw_data(sw_data), .reg_data(reg_data), .pc_en(pc_en),
    .stall(stall), .in_data(in_data), .in_valid(in_valid),
    .disp_data(disp_data), .disp_valid(disp_valid), .waiting(waiting),
    .halted(halted)
  );

  // Reference model: pending I/O kind, streak of consecutive highs,
  // release-pending flag, halt flag, and the visible data registers.
  bit            m_halt, m_rel, m_dv;
  int            m_pend;   // 0 none, 1 input, 2 output
  int            m_streak;
  logic [DW-1:0] m_in, m_disp;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check(string tag);
    bit e_pc, e_iv;
    e_pc = 1'b0;
    e_iv = 1'b0;
    if (reset && !m_halt && !m_rel) begin
      if (m_pend != 0) begin
        e_pc = Enter && (m_streak == DC - 1);
        e_iv = e_pc && (m_pend == 1);
      end else begin
        e_pc = !(Halt || Input || Output);
      end
    end
    chk({tag, ".pc_en"},      pc_en,      e_pc);
    chk({tag, ".stall"},      stall,      !e_pc);
    chk({tag, ".in_valid"},   in_valid,   e_iv);
    chk({tag, ".waiting"},    waiting,    m_pend != 0);
    chk({tag, ".halted"},     halted,     m_halt);
    chk({tag, ".in_data"},    in_data,    m_in);
    chk({tag, ".disp_data"},  disp_data,  m_disp);
    chk({tag, ".disp_valid"}, disp_valid, m_dv);
  endtask

  task automatic model_update();
    if (!reset) begin
      m_halt = 0; m_rel = 0; m_pend = 0; m_streak = 0;
      m_in = '0; m_disp = '0; m_dv = 0;
    end else begin
      m_dv = 0;
      if (m_halt) begin
      end else if (m_rel) begin
        if (!Enter) m_rel = 0;
      end else if (m_pend != 0) begin
        m_in = sw_data;
        if (Enter) begin
          if (m_streak == DC - 1) begin
            if (m_pend == 2) begin
              m_disp = reg_data;
              m_dv   = 1;
            end
            m_pend = 0; m_rel = 1; m_streak = 0;
          end else begin
            m_streak++;
          end
        end else begin
          m_streak = 0;
        end
      end else if (Halt) m_halt = 1;
      else if (Input)   m_pend = 1;
      else if (Output)  m_pend = 2;
    end
  endtask

  // One clock: drive mid-cycle, optionally compare against the model, then
  // advance the model to what the next edge will produce.
  task automatic cyc(bit r, bit e, bit i, bit o, bit h,
                     logic [DW-1:0] sw, logic [DW-1:0] rg, bit mchk, string tag);
    @(negedge clk);
    reset = r; Enter = e; Input = i; Output = o; Halt = h;
    sw_data = sw; reg_data = rg;
    #1;
    if (mchk) model_check(tag);
    model_update();
  endtask

  typedef struct {
    bit r, e, i, o, h;
    logic [DW-1:0] sw;
    bit pc, iv, wt, hl, dv;
    logic [DW-1:0] ind;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int pulses;
    bit ent;

    // Input press: 6 high samples with sw=A5, accept on the 6th
    tbl[0]  = '{0,0,0,0,0, 32'h00, 0,0,0,0,0, 32'h00};
    tbl[1]  = '{1,0,0,0,0, 32'h00, 1,0,0,0,0, 32'h00};
    tbl[2]  = '{1,0,1,0,0, 32'hA5, 0,0,0,0,0, 32'h00};
    tbl[3]  = '{1,1,0,0,0, 32'hA5, 0,0,1,0,0, 32'h00};
    tbl[4]  = '{1,1,0,0,0, 32'hA5, 0,0,1,0,0, 32'hA5};
    tbl[5]  = '{1,1,0,0,0, 32'hA5, 0,0,1,0,0, 32'hA5};
    tbl[6]  = '{1,1,0,0,0, 32'hA5, 0,0,1,0,0, 32'hA5};
    tbl[7]  = '{1,1,0,0,0, 32'hA5, 0,0,1,0,0, 32'hA5};
    tbl[8]  = '{1,1,0,0,0, 32'hA5, 1,1,1,0,0, 32'hA5};
    tbl[9]  = '{1,1,0,0,0, 32'h00, 0,0,0,0,0, 32'hA5};
    tbl[10] = '{1,0,0,0,0, 32'h00, 0,0,0,0,0, 32'hA5};
    tbl[11] = '{1,0,0,0,0, 32'h00, 1,0,0,0,0, 32'hA5};

    cyc(0,0,0,0,0, '0, '0, 0, "pre");
    cyc(0,0,0,0,0, '0, '0, 0, "pre");

    foreach (tbl[k]) begin
      cyc(tbl[k].r, tbl[k].e, tbl[k].i, tbl[k].o, tbl[k].h, tbl[k].sw, '0, 0, "tbl");
      chk($sformatf("tbl%0d.pc_en", k),      pc_en,      tbl[k].pc);
      chk($sformatf("tbl%0d.stall", k),      stall,      !tbl[k].pc);
      chk($sformatf("tbl%0d.in_valid", k),   in_valid,   tbl[k].iv);
      chk($sformatf("tbl%0d.waiting", k),    waiting,    tbl[k].wt);
      chk($sformatf("tbl%0d.halted", k),     halted,     tbl[k].hl);
      chk($sformatf("tbl%0d.disp_valid", k), disp_valid, tbl[k].dv);
      chk($sformatf("tbl%0d.in_data", k),    in_data,    tbl[k].ind);
    end

    // plain run after a fresh reset
    cyc(0,0,0,0,0, '0, '0, 1, "run_rst");
    for (int k = 0; k < 10; k++) begin
      cyc(1,0,0,0,0, '0, '0, 1, "run");
      chk("run.pc_en", pc_en, 1);
      chk("run.waiting", waiting, 0);
    end

    // press held 20 extra cycles advances only once
    pulses = 0;
    cyc(1,0,1,0,0, 32'h5A, '0, 1, "hold");
    for (int k = 0; k < DC + 20; k++) begin
      cyc(1,1,0,0,0, 32'h5A, '0, 1, "hold");
      pulses += int'(pc_en);
    end
    chk("hold.pulses", pulses, 1);
    cyc(1,0,0,0,0, '0, '0, 1, "hold_rel");

    // bounce: 1,1,1,0,1,1,1,1,1,1 accepts only on the 10th sample
    begin
      bit pat[10] = '{1,1,1,0,1,1,1,1,1,1};
      cyc(1,0,1,0,0, 32'h33, '0, 1, "bounce");
      for (int k = 0; k < 10; k++) begin
        cyc(1,pat[k],0,0,0, 32'h33, '0, 1, "bounce");
        chk($sformatf("bounce%0d.pc_en", k), pc_en, k == 9);
        if (k == 4) chk("bounce.rewait", waiting, 1);
      end
      cyc(1,0,0,0,0, '0, '0, 1, "bounce_rel");
    end

    // Output press updates the display one cycle after accept
    cyc(1,0,0,1,0, '0, 32'h1234, 1, "out");
    for (int k = 0; k < DC; k++) cyc(1,1,0,0,0, '0, 32'h1234, 1, "out");
    cyc(1,0,0,0,0, '0, 32'h9999, 1, "out_after");
    chk("out.disp_data", disp_data, 32'h1234);
    chk("out.disp_valid", disp_valid, 1);
    cyc(1,0,0,0,0, '0, '0, 1, "out_after2");
    chk("out.disp_valid_drop", disp_valid, 0);

    // Input and Output together behave as Input
    cyc(1,0,1,1,0, 32'h77, 32'hBEEF, 1, "both");
    for (int k = 0; k < DC; k++) cyc(1,1,1,1,0, 32'h77, 32'hBEEF, 1, "both");
    chk("both.in_valid", in_valid, 1);
    cyc(1,0,0,0,0, '0, 32'hBEEF, 1, "both_after");
    chk("both.disp_data", disp_data, 32'h1234);
    chk("both.disp_valid", disp_valid, 0);
    cyc(1,0,0,0,0, '0, '0, 1, "both_run");

    // Halt is absorbing until reset
    cyc(1,0,1,0,1, '0, '0, 1, "halt");
    for (int k = 0; k < 12; k++) begin
      cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom, $urandom, 1, "halted");
      chk("halt.halted", halted, 1);
      chk("halt.pc_en", pc_en, 0);
    end
    cyc(0,0,0,0,0, '0, '0, 1, "halt_rst");
    cyc(1,0,0,0,0, '0, '0, 1, "halt_run");
    chk("halt.resume_pc_en", pc_en, 1);
    chk("halt.resume_halted", halted, 0);

    // reset in DEBOUNCE at count 4 aborts the operation
    cyc(1,0,1,0,0, 32'hC3, '0, 1, "abort");
    for (int k = 0; k < 4; k++) cyc(1,1,0,0,0, 32'hC3, '0, 1, "abort");
    cyc(0,1,0,0,0, 32'hC3, '0, 1, "abort_rst");
    chk("abort.in_valid", in_valid, 0);
    chk("abort.pc_en", pc_en, 0);
    cyc(1,1,0,0,0, '0, '0, 1, "abort_after");
    chk("abort.waiting", waiting, 0);
    chk("abort.in_data", in_data, 0);
    chk("abort.disp_valid", disp_valid, 0);
    chk("abort.pc_en_run", pc_en, 1);

    // randomized traffic against the model
    ent = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(4) == 0) ent = !ent;
      cyc($urandom_range(59) != 0, ent,
          $urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(49) == 0,
          $urandom, $urandom, 1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
